// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt controller in-service logic.
package pic_pkg;

   localparam int unsigned NUM_IR     = 8;
   localparam int unsigned LVL_W      = 3;
   localparam int unsigned VEC_BASE_W = 5;

   localparam logic [LVL_W-1:0] ROTATE_DEFAULT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK1 = 2'd1,
      ST_ACK2 = 2'd2
   } state_e;

   // Interrupt vector as driven onto the data bus.
   typedef struct packed {
      logic [VEC_BASE_W-1:0] base;
      logic [LVL_W-1:0]      level;
   } vector_t;

   function automatic logic [LVL_W-1:0] encode_onehot(input logic [NUM_IR-1:0] onehot);
      logic [LVL_W-1:0] lvl;
      lvl = '0;
      for (int i = 0; i < NUM_IR; i++) begin
         if (onehot[i]) lvl = lvl | LVL_W'(i);
      end
      return lvl;
   endfunction

endpackage

// File: rtl/isr_priority_encoder.sv
// Finds the highest-priority set ISR bit; priority runs rotate+1 .. rotate (mod 8).
module isr_priority_encoder
   import pic_pkg::*;
(
   input  logic [NUM_IR-1:0] isr,
   input  logic [LVL_W-1:0]  rotate,
   output logic [LVL_W-1:0]  level_c,
   output logic              valid_c
);

   logic [LVL_W-1:0] idx;

   always_comb begin
      level_c = '0;
      valid_c = 1'b0;
      idx     = '0;
      for (int i = 1; i <= NUM_IR; i++) begin
         idx = rotate + LVL_W'(i);
         if (!valid_c && isr[idx]) begin
            valid_c = 1'b1;
            level_c = idx;
         end
      end
   end

endmodule

// File: rtl/in_service_control.sv
// In-service register, INTA acknowledge sequencing and EOI handling.
module in_service_control
   import pic_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_IR-1:0]     interrupt_from_priorty_resolver,
   input  logic                  inta_n,
   input  logic                  auto_eoi,
   input  logic                  auto_rotate,
   input  logic                  eoi_cmd,
   input  logic                  eoi_specific,
   input  logic [LVL_W-1:0]      eoi_level,
   input  logic                  rotate_on_eoi,
   input  logic [VEC_BASE_W-1:0] vector_base,
   output logic                  int_out,
   output logic [NUM_IR-1:0]     in_service_register,
   output logic [LVL_W-1:0]      rotate,
   output logic [NUM_IR-1:0]     clear_request,
   output logic [7:0]            data_out,
   output logic                  data_out_en
);

   state_e              state_q, state_d;
   logic                inta_n_q;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                spurious_q, spurious_d;
   logic                int_out_d;
   logic [NUM_IR-1:0]   isr_d, clear_d, set_mask, eoi_clr, auto_clr;
   logic [LVL_W-1:0]    rotate_d;
   logic [7:0]          data_out_d;
   logic                data_out_en_d;
   logic [LVL_W-1:0]    enc_level;
   logic                enc_valid;
   logic                inta_fall, inta_rise;
   vector_t             vec;

   assign inta_fall = inta_n_q & ~inta_n;
   assign inta_rise = ~inta_n_q & inta_n;

   isr_priority_encoder u_enc (
      .isr     (in_service_register),
      .rotate  (rotate),
      .level_c (enc_level),
      .valid_c (enc_valid)
   );

   always_comb begin
      state_d       = state_q;
      level_d       = level_q;
      spurious_d    = spurious_q;
      int_out_d     = int_out;
      clear_d       = '0;
      set_mask      = '0;
      auto_clr      = '0;
      eoi_clr       = '0;
      rotate_d      = rotate;
      data_out_d    = data_out;
      data_out_en_d = data_out_en;
      vec.base      = vector_base;
      vec.level     = level_q;

      unique case (state_q)
         ST_IDLE: begin
            if (inta_fall && int_out) begin
               state_d   = ST_ACK1;
               int_out_d = 1'b0;
               if (|interrupt_from_priorty_resolver) begin
                  level_d    = encode_onehot(interrupt_from_priorty_resolver);
                  set_mask   = NUM_IR'(1) << level_d;
                  clear_d    = set_mask;
                  spurious_d = 1'b0;
               end else begin
                  // Request vanished before the acknowledge: answer with IR7.
                  level_d    = 3'd7;
                  spurious_d = 1'b1;
               end
            end else begin
               int_out_d = |interrupt_from_priorty_resolver;
            end
         end
         ST_ACK1: begin
            if (inta_fall) begin
               state_d       = ST_ACK2;
               data_out_d    = vec;
               data_out_en_d = 1'b1;
            end
         end
         ST_ACK2: begin
            if (inta_rise) begin
               state_d       = ST_IDLE;
               data_out_en_d = 1'b0;
               if (auto_eoi && !spurious_q) begin
                  auto_clr[level_q] = 1'b1;
                  if (auto_rotate) rotate_d = level_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // EOI command; a command rotate takes precedence over an auto rotate.
      if (eoi_cmd) begin
         if (eoi_specific) begin
            eoi_clr[eoi_level] = 1'b1;
            if (rotate_on_eoi) rotate_d = eoi_level;
         end else if (enc_valid) begin
            eoi_clr[enc_level] = 1'b1;
            if (rotate_on_eoi) rotate_d = enc_level;
         end
      end

      // A set in the same cycle wins over any clear of the same bit.
      isr_d = (in_service_register & ~(eoi_clr | auto_clr)) | set_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q             <= ST_IDLE;
         inta_n_q            <= 1'b1;
         level_q             <= '0;
         spurious_q          <= 1'b0;
         int_out             <= 1'b0;
         in_service_register <= '0;
         rotate              <= ROTATE_DEFAULT;
         clear_request       <= '0;
         data_out            <= '0;
         data_out_en         <= 1'b0;
      end else begin
         state_q             <= state_d;
         inta_n_q            <= inta_n;
         level_q             <= level_d;
         spurious_q          <= spurious_d;
         int_out             <= int_out_d;
         in_service_register <= isr_d;
         rotate              <= rotate_d;
         clear_request       <= clear_d;
         data_out            <= data_out_d;
         data_out_en         <= data_out_en_d;
      end
   end

endmodule

// File: tb/tb_in_service_control.sv
// Directed, table-driven bench for in_service_control.
module tb_in_service_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] res;
   logic       inta_n, auto_eoi, auto_rotate, eoi_cmd, eoi_specific, rotate_on_eoi;
   logic [2:0] eoi_level;
   logic [4:0] vector_base;
   logic       int_out, data_out_en;
   logic [7:0] isr, clear_request, data_out;
   logic [2:0] rotate;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   in_service_control dut (
      .clk                             (clk),
      .rst_n                           (rst_n),
      .interrupt_from_priorty_resolver (res),
      .inta_n                          (inta_n),
      .auto_eoi                        (auto_eoi),
      .auto_rotate                     (auto_rotate),
      .eoi_cmd                         (eoi_cmd),
      .eoi_specific                    (eoi_specific),
      .eoi_level                       (eoi_level),
      .rotate_on_eoi                   (rotate_on_eoi),
      .vector_base                     (vector_base),
      .int_out                         (int_out),
      .in_service_register             (isr),
      .rotate                          (rotate),
      .clear_request                   (clear_request),
      .data_out                        (data_out),
      .data_out_en                     (data_out_en)
   );

   typedef struct {
      logic [7:0] res;
      logic       inta_n, eoi, spec;
      logic [2:0] lvl;
      logic       roe, aeoi, arot;
      logic       e_io;
      logic [7:0] e_isr;
      logic [2:0] e_rot;
      logic [7:0] e_clr, e_dout;
      logic       e_en;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] r, input logic ia, input logic eo, input logic sp,
                               input logic [2:0] lv, input logic ro, input logic ae, input logic ar,
                               input logic io, input logic [7:0] is, input logic [2:0] rt,
                               input logic [7:0] cl, input logic [7:0] dout, input logic en);
      vec_t v;
      v.res = r; v.inta_n = ia; v.eoi = eo; v.spec = sp; v.lvl = lv; v.roe = ro;
      v.aeoi = ae; v.arot = ar; v.e_io = io; v.e_isr = is; v.e_rot = rt;
      v.e_clr = cl; v.e_dout = dout; v.e_en = en;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic io, input logic [7:0] is,
                                input logic [2:0] rt, input logic [7:0] cl,
                                input logic [7:0] dout, input logic en);
      chk({tag, " int_out"},       8'(int_out),       8'(io));
      chk({tag, " isr"},           isr,               is);
      chk({tag, " rotate"},        8'(rotate),        8'(rt));
      chk({tag, " clear_request"}, clear_request,     cl);
      chk({tag, " data_out"},      data_out,          dout);
      chk({tag, " data_out_en"},   8'(data_out_en),   8'(en));
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      res = v.res; inta_n = v.inta_n; eoi_cmd = v.eoi; eoi_specific = v.spec;
      eoi_level = v.lvl; rotate_on_eoi = v.roe; auto_eoi = v.aeoi; auto_rotate = v.arot;
      @(posedge clk);
      #1;
      check_outputs(tag, v.e_io, v.e_isr, v.e_rot, v.e_clr, v.e_dout, v.e_en);
   endtask

   vec_t vecs[32];

   initial begin
      // Ack IR2, vector 0x42.
      vecs[0]  = mk(8'h04,1,0,0,0,0,0,0, 1,8'h00,7,8'h00,8'h00,0);
      vecs[1]  = mk(8'h04,0,0,0,0,0,0,0, 0,8'h04,7,8'h04,8'h00,0);
      vecs[2]  = mk(8'h04,1,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h00,0);
      vecs[3]  = mk(8'h04,0,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h42,1);
      vecs[4]  = mk(8'h00,1,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h42,0);
      vecs[5]  = mk(8'h00,1,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h42,0);
      // Ack IR5 so ISR = 0x24.
      vecs[6]  = mk(8'h20,1,0,0,0,0,0,0, 1,8'h04,7,8'h00,8'h42,0);
      vecs[7]  = mk(8'h20,0,0,0,0,0,0,0, 0,8'h24,7,8'h20,8'h42,0);
      vecs[8]  = mk(8'h00,1,0,0,0,0,0,0, 0,8'h24,7,8'h00,8'h42,0);
      vecs[9]  = mk(8'h00,0,0,0,0,0,0,0, 0,8'h24,7,8'h00,8'h45,1);
      vecs[10] = mk(8'h00,1,0,0,0,0,0,0, 0,8'h24,7,8'h00,8'h45,0);
      // Non-specific EOIs: rotating, non-rotating, then empty ISR.
      vecs[11] = mk(8'h00,1,1,0,0,1,0,0, 0,8'h20,2,8'h00,8'h45,0);
      vecs[12] = mk(8'h00,1,1,0,0,0,0,0, 0,8'h00,2,8'h00,8'h45,0);
      vecs[13] = mk(8'h00,1,1,0,0,1,0,0, 0,8'h00,2,8'h00,8'h45,0);
      // INTA fall with int_out low is ignored.
      vecs[14] = mk(8'h00,0,0,0,0,0,0,0, 0,8'h00,2,8'h00,8'h45,0);
      vecs[15] = mk(8'h00,1,0,0,0,0,0,0, 0,8'h00,2,8'h00,8'h45,0);
      // Auto EOI with auto rotate on IR7.
      vecs[16] = mk(8'h80,1,0,0,0,0,1,1, 1,8'h00,2,8'h00,8'h45,0);
      vecs[17] = mk(8'h80,0,0,0,0,0,1,1, 0,8'h80,2,8'h80,8'h45,0);
      vecs[18] = mk(8'h00,1,0,0,0,0,1,1, 0,8'h80,2,8'h00,8'h45,0);
      vecs[19] = mk(8'h00,0,0,0,0,0,1,1, 0,8'h80,2,8'h00,8'h47,1);
      vecs[20] = mk(8'h00,1,0,0,0,0,1,1, 0,8'h00,7,8'h00,8'h47,0);
      // Specific EOI on IR2 in the same cycle ISR[2] gets set: set wins.
      vecs[21] = mk(8'h04,1,0,0,0,0,0,0, 1,8'h00,7,8'h00,8'h47,0);
      vecs[22] = mk(8'h04,0,1,1,2,0,0,0, 0,8'h04,7,8'h04,8'h47,0);
      vecs[23] = mk(8'h00,1,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h47,0);
      vecs[24] = mk(8'h00,0,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h42,1);
      vecs[25] = mk(8'h00,1,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h42,0);
      // Spurious: request gone at the first fall.
      vecs[26] = mk(8'h08,1,0,0,0,0,0,0, 1,8'h04,7,8'h00,8'h42,0);
      vecs[27] = mk(8'h00,0,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h42,0);
      vecs[28] = mk(8'h00,1,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h42,0);
      vecs[29] = mk(8'h00,0,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h47,1);
      vecs[30] = mk(8'h00,1,0,0,0,0,0,0, 0,8'h04,7,8'h00,8'h47,0);
      // Specific rotating EOI on IR2.
      vecs[31] = mk(8'h00,1,1,1,2,1,0,0, 0,8'h00,2,8'h00,8'h47,0);

      rst_n = 1'b0; res = '0; inta_n = 1'b1; auto_eoi = 0; auto_rotate = 0;
      eoi_cmd = 0; eoi_specific = 0; eoi_level = '0; rotate_on_eoi = 0;
      vector_base = 5'b01000;
      #23;
      check_outputs("reset", 0, 8'h00, 7, 8'h00, 8'h00, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) apply(vecs[i], $sformatf("row%0d", i));

      // Reset asserted mid-ACK2 aborts the sequence.
      apply(mk(8'h01,1,0,0,0,0,0,0, 1,8'h00,2,8'h00,8'h47,0), "mr0");
      apply(mk(8'h01,0,0,0,0,0,0,0, 0,8'h01,2,8'h01,8'h47,0), "mr1");
      apply(mk(8'h00,1,0,0,0,0,0,0, 0,8'h01,2,8'h00,8'h47,0), "mr2");
      apply(mk(8'h00,0,0,0,0,0,0,0, 0,8'h01,2,8'h00,8'h40,1), "mr3");
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs("midreset", 0, 8'h00, 7, 8'h00, 8'h00, 0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(8'h00,0,0,0,0,0,0,0, 0,8'h00,7,8'h00,8'h00,0), "post0");
      apply(mk(8'h02,1,0,0,0,0,0,0, 1,8'h00,7,8'h00,8'h00,0), "post1");
      apply(mk(8'h02,0,0,0,0,0,0,0, 0,8'h02,7,8'h02,8'h00,0), "post2");
      apply(mk(8'h02,1,0,0,0,0,0,0, 0,8'h02,7,8'h00,8'h00,0), "post3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
